instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Initiator side of the opcode/control interface: fetches 32-bit MIPS instructions from instruction memory and presents them, with PC, to the decode stage (Control unit consumes `ifid_opcode`).
- Owns the PC, a request/grant/response handshake to instruction memory, and a small instruction buffer.
- Accepts branch redirects back from the execute side.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUF_DEPTH, 2, instruction buffer entries (power of 2, ≥2).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  byte address of request, word aligned.
- imem_gnt  input  1  memory accepts request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  instruction word.
- ifid_valid  output  1  buffer head holds a valid instruction.
- ifid_ready  input  1  decode stage consumes head this cycle.
- ifid_instr  output  32  head instruction.
- ifid_opcode  output  6  ifid_instr[31:26], feeds Control.opcode.
- ifid_pc  output  32  address of head instruction.
- ifid_pc4  output  32  ifid_pc + 4.
- branch_taken  input  1  redirect pulse (Branch AND zero from EX).
- branch_target  input  32  redirect address; bits[1:0] ignored (forced 0).

Behaviour:
- Clock/reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc=0, buffer empty, outstanding=0, drop=0, state=IDLE.
- FSM:
  - IDLE: go REQ when (count + outstanding) < BUF_DEPTH.
  - REQ: imem_req=1, imem_addr=pc. On imem_gnt: pc<=pc+4, outstanding<=1, go WAIT.
  - WAIT: on imem_rvalid, push {rdata, addr}, outstanding<=0. Then go REQ if space remains after the push, else IDLE.
- Only one outstanding request. Memory latency ≥1 cycle after gnt; rvalid is never in the same cycle as gnt.
- imem_addr is held stable while imem_req=1 and not granted, except on redirect.
- Buffer: FIFO; head drives ifid_*.
  - Pop when ifid_valid & ifid_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Push into an empty buffer → ifid_valid=1 the next cycle. Minimum latency from gnt to ifid_valid is 2 cycles.
  - Full: no request issued; rvalid never arrives when full, guaranteed by the space check.
- Redirect (branch_taken=1) has priority over everything else:
  - Buffer flushed (count=0, ifid_valid=0 next cycle); any pop that cycle is ignored.
  - pc<=branch_target & ~3.
  - In REQ, not granted: next cycle imem_addr=target and req stays high (retargeting an ungranted request is legal).
  - In REQ and granted the same cycle: outstanding<=1, drop<=1, pc<=target.
  - In WAIT with no rvalid: drop<=1; the response arrives later and is discarded. Then go REQ with pc=target.
  - rvalid in the same cycle as redirect: data discarded, drop not set.
  - Redirect while drop already set: pc updated, drop stays 1.
- Dropped responses clear outstanding and drop, and push nothing.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC+4 → 0; no exception.
- Reset mid-transaction: state and outputs return to reset values. A memory response arriving after reset is ignored because outstanding=0 (rvalid with outstanding=0 is ignored).

Test Plan:
- Reset then memory gnt immediate, rvalid 1 cycle later, ifid_ready=1 → imem_addr sequence 0,4,8,C. ifid_opcode follows rdata[31:26] (e.g. 6'b000000, 001000, 100011, 101011, 000100). First ifid_valid 2 cycles after first gnt.
- ifid_ready=0 → exactly 2 instructions buffered (addr 0,4), imem_req deasserts, no 3rd gnt. ifid_ready=1 one cycle → pop addr 0 and fetch of addr 8 resumes.
- branch_taken with target 32'h40 while in WAIT → buffer flushed, late response for pending addr discarded. Next imem_addr=32'h40, next ifid_pc=32'h40.
- branch_taken same cycle as gnt of addr 8 → that response dropped, then fetch 32'h44... pattern from target 32'h44 (target 32'h47 → 32'h44).
- imem_gnt held low for 3 cycles → imem_addr stable, imem_req high. Redirect mid-wait retargets the address to target next cycle.
- rst asserted while outstanding, rvalid arrives 1 cycle after rst deasserts → ignored. ifid_valid=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory and fetch/decode handshake bundle
//
// Purpose: groups the instruction-memory request/grant/response signals and the
// fetch-to-decode (IF/ID) signals so they travel as one port.
// Signals:
//   imem_req, imem_addr[31:0]           fetch request and word-aligned byte address
//   imem_gnt                            memory accepts the request this cycle
//   imem_rvalid, imem_rdata[31:0]       read response
//   ifid_valid, ifid_ready              head-of-buffer handshake with decode
//   ifid_instr, ifid_opcode, ifid_pc,
//   ifid_pc4                            head instruction, its opcode, PC and PC+4
// Modports: master = fetch unit side, slave = memory/decode side.

interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        ifid_valid;
   logic        ifid_ready;
   logic [31:0] ifid_instr;
   logic [5:0]  ifid_opcode;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc4;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output ifid_valid, ifid_instr, ifid_opcode, ifid_pc, ifid_pc4,
      input  ifid_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  ifid_valid, ifid_instr, ifid_opcode, ifid_pc, ifid_pc4,
      output ifid_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS instruction fetch unit with PC, memory handshake and buffer
//
// Purpose: owns the PC, issues one request at a time to instruction memory,
// queues returned words in a small FIFO whose head feeds decode, and handles
// branch redirects (flush, retarget, discard of in-flight responses).
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   bus            instr_fetch_unit_if.master (imem_* and ifid_* signals)
//   branch_taken   redirect pulse from execute
//   branch_target  redirect address, bits [1:0] forced to zero

module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   instr_fetch_unit_if.master        bus,
   input  logic                      branch_taken,
   input  logic [31:0]               branch_target
);
   localparam int AW = $clog2(BUF_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t        state, state_next;
   logic [31:0]   pc, pc_next;
   logic [31:0]   req_addr;
   logic          outstanding, outstanding_next;
   logic          drop, drop_next;
   logic [AW:0]   count, count_next;
   logic [AW-1:0] head, tail;
   logic [31:0]   fifo_instr [BUF_DEPTH];
   logic [31:0]   fifo_pc    [BUF_DEPTH];

   logic          resp, push, pop;
   logic [31:0]   target;

   assign target = branch_target & ~32'h3;

   // A response only counts while a request is in flight; anything else
   // (e.g. one arriving after reset) is ignored.
   assign resp = bus.imem_rvalid & outstanding;
   assign push = resp & ~drop & ~branch_taken;
   assign pop  = (count != '0) & bus.ifid_ready & ~branch_taken;

   always_comb begin
      state_next       = state;
      pc_next          = pc;
      outstanding_next = outstanding;
      drop_next        = drop;
      count_next       = branch_taken ? '0
                       : count + (AW+1)'(push) - (AW+1)'(pop);

      if (branch_taken)
         pc_next = target;

      case (state)
         IDLE: begin
            if (branch_taken ||
                (count + (AW+1)'(outstanding)) < (AW+1)'(BUF_DEPTH))
               state_next = REQ;
         end
         REQ: begin
            if (bus.imem_gnt) begin
               if (!branch_taken)
                  pc_next = pc + 32'd4;
               outstanding_next = 1'b1;
               // Granted in the same cycle as a redirect: the word belongs
               // to the old path, so mark it for discard.
               drop_next        = branch_taken;
               state_next       = WAIT;
            end
         end
         WAIT: begin
            if (resp) begin
               outstanding_next = 1'b0;
               drop_next        = 1'b0;
               state_next       = (count_next < (AW+1)'(BUF_DEPTH)) ? REQ : IDLE;
            end else if (branch_taken) begin
               drop_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         req_addr    <= RESET_PC;
         outstanding <= 1'b0;
         drop        <= 1'b0;
         count       <= '0;
         head        <= '0;
         tail        <= '0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         outstanding <= outstanding_next;
         drop        <= drop_next;
         count       <= count_next;
         if (state == REQ && bus.imem_gnt)
            req_addr <= pc;
         if (branch_taken) begin
            head <= '0;
            tail <= '0;
         end else begin
            head <= head + AW'(pop);
            tail <= tail + AW'(push);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[tail] <= bus.imem_rdata;
         fifo_pc[tail]    <= req_addr;
      end
   end

   assign bus.imem_req    = (state == REQ);
   assign bus.imem_addr   = pc;
   assign bus.ifid_valid  = (count != '0);
   assign bus.ifid_instr  = bus.ifid_valid ? fifo_instr[head] : 32'h0;
   assign bus.ifid_pc     = bus.ifid_valid ? fifo_pc[head]    : 32'h0;
   assign bus.ifid_pc4    = bus.ifid_pc + 32'd4;
   assign bus.ifid_opcode = bus.ifid_instr[31:26];
endmodule
